// File: rtl/vga_dither_pkg.sv
// Shared constants and per-channel arithmetic for the 6-to-3 bit VGA ordered dither.
package vga_dither_pkg;

    localparam int unsigned IN_W  = 6;
    localparam int unsigned OUT_W = 3;

    // 4x4 Bayer matrix, indexed by {yi, xi}
    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    typedef struct packed {
        logic [IN_W-1:0] r;
        logic [IN_W-1:0] g;
        logic [IN_W-1:0] b;
    } pixel_t;

    typedef struct packed {
        logic [OUT_W-1:0] r;
        logic [OUT_W-1:0] g;
        logic [OUT_W-1:0] b;
    } pixel_out_t;

    // Round the low bits up against the threshold; saturate instead of wrapping at full scale.
    function automatic logic [OUT_W-1:0] dither_ch(input logic [IN_W-1:0] v,
                                                   input logic [2:0]      th,
                                                   input logic            en);
        logic [OUT_W-1:0] hi;
        logic [2:0]       lo;
        hi = v[IN_W-1:IN_W-OUT_W];
        lo = v[2:0];
        if (!en || hi == 3'd7) begin
            return hi;
        end
        return hi + {2'b00, (lo > th)};
    endfunction

endpackage

// File: rtl/vga_dither_6to3_if.sv
// Pixel-side bundle between the system VGA outputs, the dither block and the DAC pins.
interface vga_dither_6to3_if;
    import vga_dither_pkg::*;

    logic             CE;
    logic             DITHER_EN;
    logic [IN_W-1:0]  R_IN;
    logic [IN_W-1:0]  G_IN;
    logic [IN_W-1:0]  B_IN;
    logic             HSYNC_IN;
    logic             VSYNC_IN;
    logic [OUT_W-1:0] R_OUT;
    logic [OUT_W-1:0] G_OUT;
    logic [OUT_W-1:0] B_OUT;
    logic             HSYNC_OUT;
    logic             VSYNC_OUT;

    modport master (
        output CE, DITHER_EN, R_IN, G_IN, B_IN, HSYNC_IN, VSYNC_IN,
        input  R_OUT, G_OUT, B_OUT, HSYNC_OUT, VSYNC_OUT
    );

    modport slave (
        input  CE, DITHER_EN, R_IN, G_IN, B_IN, HSYNC_IN, VSYNC_IN,
        output R_OUT, G_OUT, B_OUT, HSYNC_OUT, VSYNC_OUT
    );

endinterface

// File: rtl/vga_sync_pos.sv
// Stage 1 of the dither pipeline: sync edge detection, X/Y/frame counters and matrix index.
module vga_sync_pos #(
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter bit TEMPORAL    = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ce_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    output logic [1:0] xi_o,
    output logic [1:0] yi_o,
    output logic       hsync_o,
    output logic       vsync_o
);

    // hs_q/vs_q double as the stage-1 sync pipeline and the previous sample for edge detect
    logic       hs_q, vs_q;
    logic [1:0] x_q, x_d;
    logic [1:0] y_q, y_d;
    logic [1:0] f_q, f_d;
    logic [1:0] xi_q, xi_d;
    logic [1:0] yi_q, yi_d;
    logic       h_edge, v_edge;
    logic       hs_act;

    always_comb begin
        hs_act = (hsync_i == SYNC_ACTIVE);
        h_edge = hs_act && (hs_q != SYNC_ACTIVE);
        v_edge = (vsync_i == SYNC_ACTIVE) && (vs_q != SYNC_ACTIVE);

        x_d = x_q;
        if (h_edge) begin
            x_d = 2'd0;
        end else if (!hs_act) begin
            x_d = x_q + 2'd1;
        end

        y_d = y_q;
        if (v_edge) begin
            y_d = 2'd0;
        end else if (h_edge) begin
            y_d = y_q + 2'd1;
        end

        f_d = v_edge ? f_q + 2'd1 : f_q;

        // The pixel sampled now uses the position held before this cycle's update
        if (TEMPORAL) begin
            xi_d = x_q + {1'b0, f_q[0]};
            yi_d = y_q + {1'b0, f_q[1]};
        end else begin
            xi_d = x_q;
            yi_d = y_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_q <= ~SYNC_ACTIVE;
            vs_q <= ~SYNC_ACTIVE;
            x_q  <= 2'd0;
            y_q  <= 2'd0;
            f_q  <= 2'd0;
            xi_q <= 2'd0;
            yi_q <= 2'd0;
        end else if (ce_i) begin
            hs_q <= hsync_i;
            vs_q <= vsync_i;
            x_q  <= x_d;
            y_q  <= y_d;
            f_q  <= f_d;
            xi_q <= xi_d;
            yi_q <= yi_d;
        end
    end

    assign xi_o    = xi_q;
    assign yi_o    = yi_q;
    assign hsync_o = hs_q;
    assign vsync_o = vs_q;

endmodule

// File: rtl/vga_dither_6to3.sv
// Two-stage 4x4 ordered dither from 6-bit system colour to 3-bit DAC pins, syncs kept aligned.
module vga_dither_6to3 import vga_dither_pkg::*; #(
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter bit TEMPORAL    = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    vga_dither_6to3_if.slave   bus
);

    pixel_t     s1_q;
    pixel_out_t s2_q, s2_d;
    logic       hs2_q, vs2_q;
    logic       hs1, vs1;
    logic [1:0] xi, yi;
    logic [3:0] t_val;
    logic [2:0] th;

    vga_sync_pos #(
        .SYNC_ACTIVE(SYNC_ACTIVE),
        .TEMPORAL   (TEMPORAL)
    ) u_sync_pos (
        .clk_i  (CLK),
        .rst_i  (RST),
        .ce_i   (bus.CE),
        .hsync_i(bus.HSYNC_IN),
        .vsync_i(bus.VSYNC_IN),
        .xi_o   (xi),
        .yi_o   (yi),
        .hsync_o(hs1),
        .vsync_o(vs1)
    );

    // DITHER_EN is applied live to the pixel moving from stage 1 into stage 2
    always_comb begin
        t_val  = BAYER[{yi, xi}];
        th     = t_val[3:1];
        s2_d.r = dither_ch(s1_q.r, th, bus.DITHER_EN);
        s2_d.g = dither_ch(s1_q.g, th, bus.DITHER_EN);
        s2_d.b = dither_ch(s1_q.b, th, bus.DITHER_EN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q  <= '0;
            s2_q  <= '0;
            hs2_q <= ~SYNC_ACTIVE;
            vs2_q <= ~SYNC_ACTIVE;
        end else if (bus.CE) begin
            s1_q  <= '{r: bus.R_IN, g: bus.G_IN, b: bus.B_IN};
            s2_q  <= s2_d;
            hs2_q <= hs1;
            vs2_q <= vs1;
        end
    end

    assign bus.R_OUT     = s2_q.r;
    assign bus.G_OUT     = s2_q.g;
    assign bus.B_OUT     = s2_q.b;
    assign bus.HSYNC_OUT = hs2_q;
    assign bus.VSYNC_OUT = vs2_q;

endmodule
